spireg_bank: RTL and testbench

- Parametrised register bank that sits between the `spireg` SPI slave core (register side) and user logic.
- Successor to the fixed 8×8 register array: generalises width, depth and map, and adds:
  - a control register that fast commands can modify bit-wise;
  - sticky write-1-to-clear event flags with a maskable interrupt;
  - read-only hardware input registers;
  - per-address write strobes.

---
 rtl/spireg_bank_pkg.sv | 12 +
 rtl/spireg_bank_event.sv | 49 ++++
 rtl/spireg_bank.sv | 140 ++++++++++++++
 tb/tb_spireg_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spireg_bank_pkg.sv
// Shared address map and fast-command codes for spireg_bank.
// Optional IRQ/EVENT feature is selected by macro SPIREG_BANK_IRQ_EN.
package spireg_bank_pkg;

  localparam int ADDR_CTRL    = 0;
  localparam int ADDR_EVENT   = 1;
  localparam int ADDR_IRQ_EN  = 2;
  localparam int ADDR_RW_BASE = 3;

  localparam logic [5:0] FC_EVENT_CLR = 6'd63;

endpackage

// File: rtl/spireg_bank_event.sv
// Sticky W1C event flags, interrupt enable mask and registered interrupt.
// Used by spireg_bank only when SPIREG_BANK_IRQ_EN is defined.
module spireg_bank_event #(
  parameter int REG_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ev_wr,
  input  logic             en_wr,
  input  logic [REG_W-1:0] wdata,
  input  logic             clr_all,
  input  logic [REG_W-1:0] event_i,
  output logic [REG_W-1:0] event_o,
  output logic [REG_W-1:0] irq_en_o,
  output logic             irq_o
);

  logic [REG_W-1:0] event_q, event_d;
  logic [REG_W-1:0] irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
  logic [REG_W-1:0] clr;

  always_comb begin
    clr = '0;
    if (ev_wr)   clr = wdata;
    if (clr_all) clr = '1;
    // a same-cycle set beats any clear of that bit
    event_d  = (event_q & ~clr) | event_i;
    irq_en_d = en_wr ? wdata : irq_en_q;
    irq_d    = |(event_q & irq_en_q);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      event_q  <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      event_q  <= event_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign event_o  = event_q;
  assign irq_en_o = irq_en_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/spireg_bank.sv
// Parametrised register bank between the spireg SPI slave and user logic.
// Macro SPIREG_BANK_IRQ_EN enables EVENT/IRQ_EN and irq_o; otherwise addr 1/2 are plain RW.
module spireg_bank
  import spireg_bank_pkg::*;
#(
  parameter  int ADDR_W = 3,
  parameter  int REG_W  = 8,
  parameter  int N_RO   = 2,
  localparam int DEPTH  = 2**ADDR_W,
  localparam int N_RW   = DEPTH - 3 - N_RO,
  localparam int RO_W   = (N_RO > 0) ? N_RO*REG_W : 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_W-1:0]     reg_addr,
  input  logic [REG_W-1:0]      reg_data_o,
  input  logic                  reg_data_o_vld,
  input  logic [5:0]            fastcmd,
  input  logic                  fastcmd_vld,
  output logic [REG_W-1:0]      reg_data_i,
  output logic [7:0]            status,
  output logic [REG_W-1:0]      ctrl_o,
  output logic [N_RW*REG_W-1:0] rw_regs_o,
  input  logic [RO_W-1:0]       hw_ro_i,
  input  logic [REG_W-1:0]      event_i,
  output logic [DEPTH-1:0]      wr_strobe_o,
  output logic                  irq_o
);

  int addr_n;
  int fc_n;
  assign addr_n = int'(reg_addr);
  assign fc_n   = int'(fastcmd);

  logic [REG_W-1:0] ctrl_q, ctrl_d;
  logic [REG_W-1:0] rw_q [N_RW];
  logic [REG_W-1:0] rw_d [N_RW];
  logic [DEPTH-1:0] strobe_q, strobe_d;
  logic [REG_W-1:0] reg1, reg2;
  logic             fc_evt_clr, fc_to_ctrl;

`ifdef SPIREG_BANK_IRQ_EN
  assign fc_evt_clr = fastcmd_vld && (fastcmd == FC_EVENT_CLR);

  spireg_bank_event #(.REG_W(REG_W)) u_event (
    .clk      (clk),
    .nrst     (nrst),
    .ev_wr    (reg_data_o_vld && (addr_n == ADDR_EVENT)),
    .en_wr    (reg_data_o_vld && (addr_n == ADDR_IRQ_EN)),
    .wdata    (reg_data_o),
    .clr_all  (fc_evt_clr),
    .event_i  (event_i),
    .event_o  (reg1),
    .irq_en_o (reg2),
    .irq_o    (irq_o)
  );

  assign status = {irq_o, ctrl_q[6:0]};
`else
  logic [REG_W-1:0] aux1_q, aux1_d;
  logic [REG_W-1:0] aux2_q, aux2_d;
  logic             unused_event;

  assign fc_evt_clr   = 1'b0;
  assign unused_event = ^event_i;

  always_comb begin
    aux1_d = aux1_q;
    aux2_d = aux2_q;
    if (reg_data_o_vld && (addr_n == ADDR_EVENT))  aux1_d = reg_data_o;
    if (reg_data_o_vld && (addr_n == ADDR_IRQ_EN)) aux2_d = reg_data_o;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      aux1_q <= '0;
      aux2_q <= '0;
    end else begin
      aux1_q <= aux1_d;
      aux2_q <= aux2_d;
    end
  end

  assign reg1   = aux1_q;
  assign reg2   = aux2_q;
  assign irq_o  = 1'b0;
  assign status = ctrl_q[7:0];
`endif

  // a register write to CTRL in the same cycle drops the fastcmd
  assign fc_to_ctrl = fastcmd_vld && !fc_evt_clr && (fc_n < 2*REG_W) &&
                      !(reg_data_o_vld && (addr_n == ADDR_CTRL));

  always_comb begin
    ctrl_d   = ctrl_q;
    rw_d     = rw_q;
    strobe_d = '0;
    for (int a = 0; a < DEPTH; a++)
      strobe_d[a] = reg_data_o_vld && (addr_n == a);
    if (reg_data_o_vld && (addr_n == ADDR_CTRL))
      ctrl_d = reg_data_o;
    for (int i = 0; i < N_RW; i++)
      if (reg_data_o_vld && (addr_n == ADDR_RW_BASE + i))
        rw_d[i] = reg_data_o;
    for (int b = 0; b < REG_W; b++)
      if (fc_to_ctrl && ((fc_n >> 1) == b))
        ctrl_d[b] = fastcmd[0];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ctrl_q   <= '0;
      rw_q     <= '{default: '0};
      strobe_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      rw_q     <= rw_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    reg_data_i = '0;
    if (addr_n == ADDR_CTRL)   reg_data_i = ctrl_q;
    if (addr_n == ADDR_EVENT)  reg_data_i = reg1;
    if (addr_n == ADDR_IRQ_EN) reg_data_i = reg2;
    for (int i = 0; i < N_RW; i++)
      if (addr_n == ADDR_RW_BASE + i) reg_data_i = rw_q[i];
    for (int j = 0; j < N_RO; j++)
      if (addr_n == DEPTH - N_RO + j) reg_data_i = hw_ro_i[j*REG_W +: REG_W];
  end

  for (genvar g = 0; g < N_RW; g++) begin : g_rw_out
    assign rw_regs_o[g*REG_W +: REG_W] = rw_q[g];
  end

  assign ctrl_o      = ctrl_q;
  assign wr_strobe_o = strobe_q;

endmodule

// File: tb/tb_spireg_bank.sv
// Self-checking bench for spireg_bank at default parameters (8 regs, 8-bit, 2 RO).
module tb_spireg_bank;

  logic        clk = 1'b0;
  logic        nrst;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_data_o;
  logic        reg_data_o_vld;
  logic [5:0]  fastcmd;
  logic        fastcmd_vld;
  logic [7:0]  reg_data_i;
  logic [7:0]  status;
  logic [7:0]  ctrl_o;
  logic [23:0] rw_regs_o;
  logic [15:0] hw_ro_i;
  logic [7:0]  event_i;
  logic [7:0]  wr_strobe_o;
  logic        irq_o;

  always #5 clk = ~clk;

  spireg_bank dut (
    .clk(clk), .nrst(nrst), .reg_addr(reg_addr), .reg_data_o(reg_data_o),
    .reg_data_o_vld(reg_data_o_vld), .fastcmd(fastcmd), .fastcmd_vld(fastcmd_vld),
    .reg_data_i(reg_data_i), .status(status), .ctrl_o(ctrl_o), .rw_regs_o(rw_regs_o),
    .hw_ro_i(hw_ro_i), .event_i(event_i), .wr_strobe_o(wr_strobe_o), .irq_o(irq_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: one storage word per non-RO address
  logic [7:0] m_mem [6];
  logic       m_irq;
  logic [7:0] m_strb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_read(input int a);
    if (a < 6) return m_mem[a];
    return hw_ro_i[(a-6)*8 +: 8];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_mem[i] = 8'h00;
    m_irq  = 1'b0;
    m_strb = 8'h00;
  endtask

  task automatic model_step(input logic vld, input int a, input logic [7:0] d,
                            input logic fcv, input int fc, input logic [7:0] ev);
    logic [7:0] nm [6];
    logic [7:0] clr;
    nm = m_mem;
    clr = 8'h00;
    m_strb = vld ? 8'(1 << a) : 8'h00;
`ifdef SPIREG_BANK_IRQ_EN
    m_irq = |(m_mem[1] & m_mem[2]);
    if (vld && a == 1) clr = d;
    else if (vld && a < 6) nm[a] = d;
    if (fcv && fc == 63) clr = 8'hFF;
    nm[1] = (m_mem[1] & ~clr) | ev;
`else
    m_irq = 1'b0;
    if (vld && a < 6) nm[a] = d;
`endif
    if (fcv && fc < 16 && !(vld && a == 0)) nm[0][fc/2] = fc[0];
    m_mem = nm;
  endtask

  task automatic check_all();
    check("reg_data_i", reg_data_i, m_read(int'(reg_addr)));
    check("ctrl_o", ctrl_o, m_mem[0]);
    check("rw_regs_o", rw_regs_o, {m_mem[5], m_mem[4], m_mem[3]});
    check("wr_strobe_o", wr_strobe_o, m_strb);
    check("irq_o", irq_o, m_irq);
`ifdef SPIREG_BANK_IRQ_EN
    check("status", status, {m_irq, m_mem[0][6:0]});
`else
    check("status", status, m_mem[0]);
`endif
  endtask

  task automatic cycle(input logic vld, input logic [2:0] a, input logic [7:0] d,
                       input logic fcv, input logic [5:0] fc, input logic [7:0] ev);
    reg_data_o_vld = vld; reg_addr = a; reg_data_o = d;
    fastcmd_vld = fcv; fastcmd = fc; event_i = ev;
    @(posedge clk);
    model_step(vld, int'(a), d, fcv, int'(fc), ev);
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    logic       vld;
    logic [2:0] a;
    logic [7:0] d;
    logic       fcv;
    logic [5:0] fc;
    logic [7:0] exp_rd;
    logic [7:0] exp_ctrl;
    logic [7:0] exp_strb;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 3'd3, 8'hA5, 1'b0, 6'd0,  8'hA5, 8'h00, 8'h08};
    vecs[1]  = '{1'b0, 3'd3, 8'h00, 1'b0, 6'd0,  8'hA5, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 3'd0, 8'h00, 1'b1, 6'd1,  8'h01, 8'h01, 8'h00};
    vecs[3]  = '{1'b0, 3'd0, 8'h00, 1'b1, 6'd5,  8'h05, 8'h05, 8'h00};
    vecs[4]  = '{1'b0, 3'd0, 8'h00, 1'b1, 6'd15, 8'h85, 8'h85, 8'h00};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 1'b1, 6'd4,  8'h81, 8'h81, 8'h00};
    vecs[6]  = '{1'b0, 3'd0, 8'h00, 1'b1, 6'd40, 8'h81, 8'h81, 8'h00};
    vecs[7]  = '{1'b0, 3'd6, 8'h00, 1'b0, 6'd0,  8'hEF, 8'h81, 8'h00};
    vecs[8]  = '{1'b0, 3'd7, 8'h00, 1'b0, 6'd0,  8'hBE, 8'h81, 8'h00};
    vecs[9]  = '{1'b1, 3'd6, 8'h00, 1'b0, 6'd0,  8'hEF, 8'h81, 8'h40};
    vecs[10] = '{1'b0, 3'd6, 8'h00, 1'b0, 6'd0,  8'hEF, 8'h81, 8'h00};
    vecs[11] = '{1'b1, 3'd0, 8'h3C, 1'b1, 6'd1,  8'h3C, 8'h3C, 8'h01};
    vecs[12] = '{1'b1, 3'd4, 8'h5A, 1'b1, 6'd3,  8'h5A, 8'h3E, 8'h10};

    nrst = 1'b0;
    reg_addr = 3'd0; reg_data_o = 8'h00; reg_data_o_vld = 1'b0;
    fastcmd = 6'd0; fastcmd_vld = 1'b0; event_i = 8'h00; hw_ro_i = 16'hBEEF;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    nrst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].vld, vecs[i].a, vecs[i].d, vecs[i].fcv, vecs[i].fc, 8'h00);
      check($sformatf("vec%0d rd", i), reg_data_i, vecs[i].exp_rd);
      check($sformatf("vec%0d ctrl", i), ctrl_o, vecs[i].exp_ctrl);
      check($sformatf("vec%0d strb", i), wr_strobe_o, vecs[i].exp_strb);
`ifdef SPIREG_BANK_IRQ_EN
      if (i == 5) check("status_irq_off", status, 8'h01);
`else
      if (i == 5) check("status_ctrl7", status, 8'h81);
`endif
    end

`ifdef SPIREG_BANK_IRQ_EN
    cycle(1'b1, 3'd2, 8'h04, 1'b0, 6'd0, 8'h00);
    cycle(1'b0, 3'd1, 8'h00, 1'b0, 6'd0, 8'h04);
    check("event_set", reg_data_i, 8'h04);
    check("irq_1cyc", irq_o, 1'b0);
    cycle(1'b0, 3'd1, 8'h00, 1'b0, 6'd0, 8'h00);
    check("irq_2cyc", irq_o, 1'b1);
    cycle(1'b1, 3'd1, 8'h04, 1'b0, 6'd0, 8'h00);
    check("event_w1c", reg_data_i, 8'h00);
    check("irq_hold", irq_o, 1'b1);
    cycle(1'b0, 3'd1, 8'h00, 1'b0, 6'd0, 8'h00);
    check("irq_clr", irq_o, 1'b0);
    cycle(1'b1, 3'd1, 8'h04, 1'b0, 6'd0, 8'h04);
    check("set_beats_w1c", reg_data_i, 8'h04);
    cycle(1'b0, 3'd1, 8'h00, 1'b1, 6'd63, 8'h02);
    check("fc63_set_beats", reg_data_i, 8'h02);
    cycle(1'b0, 3'd1, 8'h00, 1'b1, 6'd63, 8'h00);
    check("fc63_clear", reg_data_i, 8'h00);
`else
    cycle(1'b1, 3'd1, 8'h66, 1'b0, 6'd0, 8'hFF);
    check("addr1_plain", reg_data_i, 8'h66);
    cycle(1'b1, 3'd2, 8'h99, 1'b1, 6'd63, 8'hFF);
    check("addr2_plain", reg_data_i, 8'h99);
    check("irq_tied", irq_o, 1'b0);
`endif

    for (int k = 0; k < 400; k++) begin
      logic [5:0] fc;
      logic [7:0] ev;
      if (k % 16 == 0) hw_ro_i = 16'($urandom);
      fc = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 47));
      ev = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom_range(0, 1)), fc, ev);
    end

    cycle(1'b1, 3'd0, 8'hFF, 1'b0, 6'd0, 8'h00);
    cycle(1'b1, 3'd2, 8'hFF, 1'b0, 6'd0, 8'h00);
    cycle(1'b0, 3'd1, 8'h00, 1'b0, 6'd0, 8'h10);
    cycle(1'b0, 3'd3, 8'h00, 1'b0, 6'd0, 8'h00);
    reg_data_o_vld = 1'b1; reg_addr = 3'd3; reg_data_o = 8'h77;
    #2;
    nrst = 1'b0;
    model_reset();
    #1;
    check("rst_ctrl", ctrl_o, 8'h00);
    check("rst_irq", irq_o, 1'b0);
    check("rst_rw", rw_regs_o, 24'h0);
    check("rst_strb", wr_strobe_o, 8'h00);
    check_all();
    @(posedge clk);
    @(negedge clk);
    reg_data_o_vld = 1'b0;
    nrst = 1'b1;
    check_all();
    cycle(1'b0, 3'd3, 8'h00, 1'b0, 6'd0, 8'h00);
    check("no_partial_write", reg_data_i, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
